// File: rtl/mdu_ctrl_pkg.sv
// Shared constants for the multiply/divide unit controller:
// default widths, operation codes and FSM state encodings.
package mdu_ctrl_pkg;

    localparam int DATA_SIZE_DEF = 32;
    localparam int CNT_SIZE_DEF  = 6;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_ctrl_sig_extend.sv
// Sign extension of a narrow operand to a wider datapath.
// Used to widen signed operands by one bit before magnitude conversion.
module sig_extend #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 33
) (
    input  logic [IN_W-1:0]  i_data,
    output logic [OUT_W-1:0] o_data
);

    assign o_data = {{(OUT_W-IN_W){i_data[IN_W-1]}}, i_data};

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide,
// one step per cycle on a DATA_SIZE+1 bit adder, with HI/LO registers.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int CNT_SIZE  = CNT_SIZE_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic [1:0]           i_op,
    input  logic [DATA_SIZE-1:0] i_rs,
    input  logic [DATA_SIZE-1:0] i_rt,
    input  logic                 i_mthi,
    input  logic                 i_mtlo,
    input  logic                 i_flush,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_div_by_zero,
    output logic [DATA_SIZE-1:0] o_hi,
    output logic [DATA_SIZE-1:0] o_lo
);

    localparam int DS = DATA_SIZE;
    localparam int W  = DATA_SIZE + 1;
    localparam logic [CNT_SIZE-1:0] CNT_LOAD = CNT_SIZE'(DATA_SIZE);

    logic [1:0]          state_q, state_d;
    logic [CNT_SIZE-1:0] cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic                sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
    logic [W-1:0]        a_q, a_d, b_q, b_d;
    logic [DS-1:0]       acc_q, acc_d, wrk_q, wrk_d;
    logic [DS-1:0]       hi_q, hi_d, lo_q, lo_d;

    logic [W-1:0] rs_sx, rt_sx, rs_ext, rt_ext, rs_mag, rt_mag;
    logic         sgn_in, idle_like;

    sig_extend #(.IN_W(DS), .OUT_W(W)) u_sx_rs (.i_data(i_rs), .o_data(rs_sx));
    sig_extend #(.IN_W(DS), .OUT_W(W)) u_sx_rt (.i_data(i_rt), .o_data(rt_sx));

    assign sgn_in    = op_is_signed(i_op);
    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);

    always_comb begin
        rs_ext = sgn_in ? rs_sx : {1'b0, i_rs};
        rt_ext = sgn_in ? rt_sx : {1'b0, i_rt};
        rs_mag = (sgn_in & i_rs[DS-1]) ? -rs_ext : rs_ext;
        rt_mag = (sgn_in & i_rt[DS-1]) ? -rt_ext : rt_ext;
    end

    // Shared adder: multiply adds the multiplicand, divide subtracts the divisor.
    logic [W-1:0] add_a, add_b;
    logic         add_ci, carry;
    logic [W:0]   sum;

    always_comb begin
        if (op_q[1]) begin
            add_a  = {acc_q, wrk_q[DS-1]};
            add_b  = ~b_q;
            add_ci = 1'b1;
        end else begin
            add_a  = {1'b0, acc_q};
            add_b  = wrk_q[0] ? a_q : '0;
            add_ci = 1'b0;
        end
        sum   = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};
        carry = sum[W];
    end

    logic [2*DS-1:0] prod, prod_s;
    logic [DS-1:0]   quo_s, rem_s;
    logic            neg_res;

    always_comb begin
        neg_res = op_is_signed(op_q) & (sa_q ^ sb_q);
        prod    = {acc_q, wrk_q};
        prod_s  = neg_res ? -prod : prod;
        quo_s   = neg_res ? -wrk_q : wrk_q;
        rem_s   = (op_is_signed(op_q) & sa_q) ? -acc_q : acc_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        wrk_d   = wrk_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (idle_like && i_mthi) hi_d = i_rs;
        if (idle_like && i_mtlo) lo_d = i_rs;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_LOAD;
                    op_d    = i_op;
                    sa_d    = sgn_in & i_rs[DS-1];
                    sb_d    = sgn_in & i_rt[DS-1];
                    dz_d    = i_op[1] & (i_rt == '0);
                    a_d     = rs_mag;
                    b_d     = rt_mag;
                    acc_d   = '0;
                    wrk_d   = i_op[1] ? rs_mag[DS-1:0] : rt_mag[DS-1:0];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_SIZE'(1)) state_d = ST_FIX;
                if (op_q[1]) begin
                    acc_d = carry ? sum[DS-1:0] : add_a[DS-1:0];
                    wrk_d = {wrk_q[DS-2:0], carry};
                end else begin
                    acc_d = sum[W-1:1];
                    wrk_d = {sum[0], wrk_q[DS-1:1]};
                end
            end
            default: begin
                state_d = ST_DONE;
                if (!i_flush) begin
                    if (op_q[1]) begin
                        hi_d = rem_s;
                        lo_d = dz_q ? '1 : quo_s;
                    end else begin
                        hi_d = prod_s[2*DS-1:DS];
                        lo_d = prod_s[DS-1:0];
                    end
                end
            end
        endcase

        if (i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            wrk_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            wrk_q   <= wrk_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign o_busy        = (state_q == ST_RUN) || (state_q == ST_FIX);
    assign o_done        = (state_q == ST_DONE);
    assign o_div_by_zero = (state_q == ST_DONE) && dz_q;
    assign o_hi          = hi_q;
    assign o_lo          = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus random
// traffic compared every cycle against an arithmetic reference model.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs = '0, rt = '0;
    logic        mthi = 1'b0, mtlo = 1'b0, flush = 1'b0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    mdu_ctrl #(.DATA_SIZE(32), .CNT_SIZE(6)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_op(op),
        .i_rs(rs), .i_rt(rt), .i_mthi(mthi), .i_mtlo(mtlo),
        .i_flush(flush), .o_busy(busy), .o_done(done),
        .o_div_by_zero(dz), .o_hi(hi), .o_lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        else
            n_pass++;
    endtask

    // Reference arithmetic on 64-bit integers.
    function automatic void calc(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] h,
                                 output logic [31:0] l, output logic z);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic [63:0]     p;
        z = 1'b0;
        h = '0;
        l = '0;
        p = '0;
        if (o == 2'b00) begin
            p = 64'(sa * sb);
            h = p[63:32];
            l = p[31:0];
        end else if (o == 2'b01) begin
            p = ua * ub;
            h = p[63:32];
            l = p[31:0];
        end else if (b == 0) begin
            z = 1'b1;
            l = '1;
            h = a;
        end else if (o == 2'b10) begin
            l = 32'(sa / sb);
            h = 32'(sa % sb);
        end else begin
            l = 32'(ua / ub);
            h = 32'(ua % ub);
        end
    endfunction

    // Behavioural model: busy countdown, one-cycle done, pending result.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_done, m_dz, p_dz;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_done = 0; m_dz = 0; m_left = 0;
        end else begin
            if (m_left == 0 && mthi) m_hi = rs;
            if (m_left == 0 && mtlo) m_lo = rs;
            if (flush) begin
                m_left = 0; m_done = 0; m_dz = 0;
            end else if (m_left == 0) begin
                m_done = 0; m_dz = 0;
                if (start) begin
                    calc(op, rs, rt, p_hi, p_lo, p_dz);
                    m_left = 33;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1; m_dz = p_dz; m_hi = p_hi; m_lo = p_lo;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_left > 0));
            chk("done", 64'(done), 64'(m_done));
            chk("dz",   64'(dz),   64'(m_dz));
            chk("hi",   64'(hi),   64'(m_hi));
            chk("lo",   64'(lo),   64'(m_lo));
        end
    end

    task automatic idle_in();
        start = 0; mthi = 0; mtlo = 0; flush = 0;
    endtask

    task automatic start_op(input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, output int k);
        @(negedge clk);
        op = o; rs = a; rt = b; start = 1;
        @(posedge clk);
        #1 k = cyc;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input int k, output int dcyc);
        int n = 0;
        dcyc = -1;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                dcyc = cyc + 1 - k;
                break;
            end
        end
    endtask

    task automatic run_lit(input string nm, input logic [1:0] o,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el,
                           input logic ez);
        int k, d;
        start_op(o, a, b, k);
        wait_done(k, d);
        chk({nm, "_lat"}, 64'(d), 64'(34));
        chk({nm, "_hi"}, 64'(hi), 64'(eh));
        chk({nm, "_lo"}, 64'(lo), 64'(el));
        chk({nm, "_dz"}, 64'(dz), 64'(ez));
    endtask

    task automatic mt_write(input logic [31:0] vh, input logic [31:0] vl);
        @(negedge clk);
        rs = vh; mthi = 1;
        @(negedge clk);
        mthi = 0; rs = vl; mtlo = 1;
        @(negedge clk);
        mtlo = 0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, d;
        bit seen;
        idle_in();
        #23;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hilo", {hi, lo}, 64'(0));
        @(negedge clk);
        rst_n = 1;
        chk_en = 1;

        run_lit("mult", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
        run_lit("multu", 2'b01, '1, '1, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_lit("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_lit("divu0", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1);
        run_lit("divmin", 2'b10, 32'h8000_0000, '1, 32'h0, 32'h8000_0000, 0);
        run_lit("div0s", 2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1);

        // Start during busy must be ignored.
        start_op(2'b00, 32'd5, 32'd7, k);
        repeat (4) @(negedge clk);
        op = 2'b01; rs = 32'd9; rt = 32'd9; start = 1;
        @(negedge clk);
        start = 0;
        wait_done(k, d);
        chk("ign_lat", 64'(d), 64'(34));
        chk("ign_res", {hi, lo}, 64'd35);

        // Back-to-back start accepted in the DONE cycle.
        start_op(2'b11, 32'd100, 32'd7, k);
        wait_done(k, d);
        chk("b2b1_res", {hi, lo}, {32'd2, 32'd14});
        op = 2'b00; rs = 32'h0001_0000; rt = 32'h0001_0000; start = 1;
        @(posedge clk);
        #1 k2 = cyc;
        chk("b2b_busy", 64'(busy), 64'(1));
        @(negedge clk);
        start = 0;
        wait_done(k2, d);
        chk("b2b2_lat", 64'(d), 64'(34));
        chk("b2b2_res", {hi, lo}, {32'd1, 32'd0});

        // Flush mid-run leaves HI/LO at their written values.
        mt_write(32'h1234_5678, 32'h9ABC_DEF0);
        chk("mt_res", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        start_op(2'b00, 32'd3, 32'd3, k);
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("fl_busy", 64'(busy), 64'(0));
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("fl_nodone", 64'(seen), 64'(0));
        chk("fl_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

        // Asynchronous reset mid-run.
        start_op(2'b01, 32'd11, 32'd13, k);
        repeat (7) @(negedge clk);
        #3 rst_n = 0;
        #1;
        chk("ar_busy", 64'(busy), 64'(0));
        chk("ar_hilo", {hi, lo}, 64'(0));
        chk("ar_done", 64'(done), 64'(0));
        @(negedge clk);
        rst_n = 1;
        run_lit("post_rst", 2'b00, '1, '1, 32'h0, 32'h1, 0);

        // Random traffic against the model.
        repeat (3000) begin
            @(negedge clk);
            start = ($urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 99) == 0);
            mthi  = ($urandom_range(0, 19) == 0);
            mtlo  = ($urandom_range(0, 19) == 0);
            op    = 2'($urandom_range(0, 3));
            rs    = pick();
            rt    = pick();
        end
        @(negedge clk);
        idle_in();
        repeat (40) @(negedge clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
